display_scheduler: RTL and testbench

- Shares the single 5-digit seven-segment display between three Booth-datapath sources: product (16-bit signed), multiplicand (8-bit signed) and multiplier (8-bit signed).
- Round-robin arbitration picks one source; the captured value is converted sequentially with shift-add-3 (double dabble).
- Drives the 21-bit sign+BCD word (codigo_BCD) consumed by sevenSegmentDisplay.

---
 rtl/display_scheduler.sv | 156 +++++++++++++++
 tb/tb_display_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Round-robin display scheduler: grants one of three Booth sources, converts it to sign+BCD
// with a sequential double dabble. Optional display hold selected by `define DISPLAY_HOLD_EN.
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] product,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic [2:0]  ack,
    output logic        busy,
    output logic [1:0]  src_sel,
    output logic        bcd_valid,
    output logic [20:0] codigo_BCD
);

`ifdef DISPLAY_HOLD_EN
    typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone, StHold} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone} state_e;
`endif

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_last, r_grant, w_pick;
    logic        r_sign;
    logic [15:0] r_mag, w_value;
    logic [19:0] r_bcd, w_bcd_adj, w_bcd_shl;
    logic [3:0]  r_cnt;
    logic [20:0] r_code;
    logic [1:0]  r_src;
    logic        w_req_any;

    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       hit;
        pick = 2'd0;
        hit  = 1'b0;
        idx  = (last == 2'd2) ? 2'd0 : last + 2'd1;
        for (int i = 0; i < 3; i++) begin
            if (!hit && r[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return pick;
    endfunction

    assign w_req_any = |req;
    assign w_pick    = rr_pick(req, r_last);

    always_comb begin
        unique case (r_grant)
            2'd1:    w_value = {{8{multiplicand[7]}}, multiplicand};
            2'd2:    w_value = {{8{multiplier[7]}}, multiplier};
            default: w_value = product;
        endcase
    end

    always_comb begin
        for (int n = 0; n < 5; n++) begin
            w_bcd_adj[n*4 +: 4] = (r_bcd[n*4 +: 4] >= 4'd5) ? r_bcd[n*4 +: 4] + 4'd3
                                                            : r_bcd[n*4 +: 4];
        end
        w_bcd_shl = {w_bcd_adj[18:0], r_mag[15]};
    end

`ifdef DISPLAY_HOLD_EN
    logic [31:0] r_hold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold <= '0;
        end else if (r_state == StDone) begin
            r_hold <= (HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 32'd0;
        end else if (r_state == StHold && r_hold != '0) begin
            r_hold <= r_hold - 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The last post-conversion cycle doubles as an arbitration slot, so pending
    // requests are granted without an extra IDLE cycle (18-cycle period).
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_req_any) w_state_nxt = StLoad;
            StLoad:  w_state_nxt = StShift;
            StShift: if (r_cnt == 4'd15) w_state_nxt = StDone;
`ifdef DISPLAY_HOLD_EN
            StDone:  w_state_nxt = StHold;
            StHold:  if (r_hold == '0) w_state_nxt = w_req_any ? StLoad : StIdle;
`else
            StDone:  w_state_nxt = w_req_any ? StLoad : StIdle;
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        ack       = 3'b000;
        busy      = (r_state != StIdle);
        bcd_valid = (r_state == StDone);
        if (r_state == StLoad) ack = 3'b001 << r_grant;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last  <= 2'd2;
            r_grant <= 2'd0;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_src   <= 2'd3;
        end else begin
            if (r_state != StLoad && w_state_nxt == StLoad) r_grant <= w_pick;
            unique case (r_state)
                StLoad: begin
                    r_sign <= w_value[15];
                    r_mag  <= w_value[15] ? (~w_value + 16'd1) : w_value;
                    r_bcd  <= '0;
                    r_cnt  <= '0;
                    r_last <= r_grant;
                end
                StShift: begin
                    r_bcd <= w_bcd_shl;
                    r_mag <= {r_mag[14:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    // Publish on entry to DONE so bcd_valid and the new word coincide.
                    if (r_cnt == 4'd15) begin
                        r_code <= {r_sign, w_bcd_shl};
                        r_src  <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign codigo_BCD = r_code;
    assign src_sel    = r_src;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: directed cases plus random request rounds.
module tb_display_scheduler;

`ifdef DISPLAY_HOLD_EN
    localparam int Spacing = 18 + 10;
`else
    localparam int Spacing = 18;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] product;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [2:0]  ack;
    logic        busy;
    logic [1:0]  src_sel;
    logic        bcd_valid;
    logic [20:0] codigo_BCD;

    display_scheduler #(.HOLD_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .product     (product),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .ack         (ack),
        .busy        (busy),
        .src_sel     (src_sel),
        .bcd_valid   (bcd_valid),
        .codigo_BCD  (codigo_BCD)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [20:0] code;
    } res_t;

    int   exp_ack[$];
    res_t exp_res[$];
    int   ack_log[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    int   m_last = 2;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] model_code(input int v);
        int          m;
        logic [20:0] c;
        m     = (v < 0) ? -v : v;
        c[20] = (v < 0);
        for (int d = 0; d < 5; d++) begin
            c[d*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return c;
    endfunction

    // Monitor: pops expectations whenever the DUT presents ack or bcd_valid.
    always @(negedge clk) begin
        if (reset) begin
            if (ack != 3'b000) begin
                if (exp_ack.size() == 0) begin
                    check("unexpected_ack", {29'd0, ack}, 32'd0);
                end else begin
                    int          e;
                    logic [2:0]  oh;
                    e  = exp_ack.pop_front();
                    oh = 3'b001 << e;
                    check("ack_onehot", {29'd0, ack}, {29'd0, oh});
                    check("busy_at_ack", {31'd0, busy}, 32'd1);
                end
                last_ack_cyc = cyc;
                ack_log.push_back(cyc);
            end
            if (bcd_valid) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_bcd_valid", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    check("codigo_BCD", {11'd0, codigo_BCD}, {11'd0, r.code});
                    check("src_sel", {30'd0, src_sel}, r.src);
                    check("ack_to_valid_latency", cyc - last_ack_cyc, 32'd17);
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((exp_res.size() != 0 || exp_ack.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'd0, (exp_res.size() != 0 || exp_ack.size() != 0)}, 32'd0);
    endtask

    task automatic do_round(input logic [2:0] mask, input logic [15:0] p, input logic [7:0] mc,
                            input logic [7:0] mp);
        int   idx;
        int   n;
        int   val;
        res_t r;
        @(negedge clk);
        product      = p;
        multiplicand = mc;
        multiplier   = mp;
        idx = (m_last + 1) % 3;
        for (int i = 0; i < 3; i++) begin
            if (mask[idx]) begin
                val    = (idx == 0) ? int'($signed(p)) :
                         (idx == 1) ? int'($signed(mc)) : int'($signed(mp));
                r.src  = idx;
                r.code = model_code(val);
                exp_ack.push_back(idx);
                exp_res.push_back(r);
                m_last = idx;
            end
            idx = (idx + 1) % 3;
        end
        req = mask;
        n   = 0;
        while (req != 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
            req = req & ~ack;
        end
        check("round_timeout", {29'd0, req}, 32'd0);
        req = 3'b000;
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        req          = 3'b000;
        product      = '0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {29'd0, ack}, 32'd0);
        check("rst_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_code", {11'd0, codigo_BCD}, 32'd0);
        check("rst_src", {30'd0, src_sel}, 32'd3);
        reset = 1'b1;

        do_round(3'b001, 16'h1F40, 8'h00, 8'h00);
        do_round(3'b010, 16'h0000, 8'h80, 8'h00);
        do_round(3'b100, 16'h0000, 8'h00, 8'h00);
        wait_drain();

        ack_log.delete();
        do_round(3'b111, 16'hFFFF, 8'h7F, 8'hF6);
        wait_drain();
        check("ack_count_111", ack_log.size(), 32'd3);
        if (ack_log.size() == 3) begin
            check("ack_spacing_01", ack_log[1] - ack_log[0], Spacing);
            check("ack_spacing_12", ack_log[2] - ack_log[1], Spacing);
        end

        do_round(3'b001, 16'h8000, 8'h00, 8'h00);
        do_round(3'b001, 16'h4000, 8'h00, 8'h00);
        // A short request while busy must be dropped unserved.
        @(negedge clk);
        req = 3'b010;
        repeat (2) @(negedge clk);
        req = 3'b000;
        wait_drain();

        // Mid-conversion reset: the in-flight result is discarded.
        @(negedge clk);
        product = 16'd1234;
        exp_ack.push_back(0);
        req = 3'b001;
        n   = 0;
        while (ack == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_case_ack_timeout", {31'd0, (ack == 3'b000)}, 32'd0);
        req = 3'b000;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_code", {11'd0, codigo_BCD}, 32'd0);
        check("midrst_src", {30'd0, src_sel}, 32'd3);
        check("midrst_valid", {31'd0, bcd_valid}, 32'd0);
        reset  = 1'b1;
        m_last = 2;
        do_round(3'b110, 16'h0000, 8'd77, 8'h9C);
        wait_drain();

        for (int k = 0; k < 20; k++) begin
            do_round(3'($urandom_range(1, 7)), 16'($urandom), 8'($urandom), 8'($urandom));
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
